// File: rtl/crc_stream_gen.sv
// Byte-stream CRC engine with valid/ready framing. Append mode inserts the
// CRC bytes after each packet; check mode compares the raw register to a residue.
module crc_stream_gen #(
    parameter int          CRC_W       = 32,
    parameter logic [31:0] POLY        = 32'h04C11DB7,
    parameter logic [31:0] INIT        = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT     = 32'h00000000,
    parameter bit          REFLECT_IN  = 1'b0,
    parameter bit          REFLECT_OUT = 1'b0,
    parameter bit          APPEND      = 1'b1,
    parameter logic [31:0] RESIDUE     = 32'h00000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic             s_sop_i,
    input  logic             s_eop_i,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             m_sop_o,
    output logic             m_eop_o,
    output logic [CRC_W-1:0] crc_out_o,
    output logic             crc_done_o,
    output logic             crc_ok_o,
    output logic             frame_err_o
);
    localparam int               NB        = CRC_W / 8;
    localparam logic [CRC_W-1:0] POLY_W    = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_W    = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_W     = XOR_OUT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];
    localparam logic [1:0]       LAST_IDX  = 2'(NB - 1);

    typedef enum logic {ST_PASS, ST_APPEND} state_t;

    function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c, input logic [7:0] b);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[CRC_W-1] ^ (REFLECT_IN ? b[i] : b[3'(7 - i)]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] crc_rev(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = c[CRC_W-1-i];
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_out_q, crc_out_d;
    logic             in_frame_q, in_frame_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d, m_sop_q, m_sop_d, m_eop_q, m_eop_d;
    logic             crc_done_q, crc_done_d, crc_ok_q, crc_ok_d, ferr_q, ferr_d;
    logic [1:0]       idx_q, idx_d;

    logic             s_ready, accept, fold, m_free;
    logic [CRC_W-1:0] crc_new;
    logic [1:0]       byte_sel;

    assign m_free    = !m_valid_q || m_ready_i;
    assign s_ready   = (state_q == ST_PASS) && m_free;
    assign accept    = s_valid_i && s_ready && !init_i;
    // Bytes arriving outside a frame without SOP are forwarded but never folded.
    assign fold      = accept && (s_sop_i || in_frame_q);
    assign crc_new   = crc_fold(s_sop_i ? INIT_W : crc_q, s_data_i);
    assign byte_sel  = REFLECT_OUT ? idx_q : (LAST_IDX - idx_q);

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        crc_out_d  = crc_out_q;
        in_frame_d = in_frame_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q && !m_ready_i;
        m_sop_d    = m_sop_q;
        m_eop_d    = m_eop_q;
        crc_done_d = 1'b0;
        crc_ok_d   = crc_ok_q;
        ferr_d     = 1'b0;
        idx_d      = idx_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data_i;
            m_sop_d   = s_sop_i;
            m_eop_d   = s_eop_i && !(APPEND && fold);
            ferr_d    = !fold || (s_sop_i && in_frame_q);
            if (fold) begin
                crc_d      = crc_new;
                in_frame_d = !s_eop_i;
                if (s_eop_i) begin
                    crc_out_d  = (REFLECT_OUT ? crc_rev(crc_new) : crc_new) ^ XOR_W;
                    crc_done_d = 1'b1;
                    if (APPEND) begin
                        state_d = ST_APPEND;
                        idx_d   = 2'd0;
                    end else begin
                        crc_ok_d = (crc_new == RESIDUE_W);
                    end
                end
            end
        end else if (state_q == ST_APPEND && m_free) begin
            // crc_out_q is already final here: it was written with the EOP byte.
            m_valid_d = 1'b1;
            m_data_d  = 8'(crc_out_q >> {byte_sel, 3'b000});
            m_sop_d   = 1'b0;
            m_eop_d   = (idx_q == LAST_IDX);
            idx_d     = idx_q + 2'd1;
            if (idx_q == LAST_IDX) state_d = ST_PASS;
        end

        if (init_i) begin
            state_d    = ST_PASS;
            crc_d      = INIT_W;
            in_frame_d = 1'b0;
            m_valid_d  = 1'b0;
            m_data_d   = 8'd0;
            m_sop_d    = 1'b0;
            m_eop_d    = 1'b0;
            crc_done_d = 1'b0;
            ferr_d     = 1'b0;
            idx_d      = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_PASS;
            crc_q      <= INIT_W;
            crc_out_q  <= '0;
            in_frame_q <= 1'b0;
            m_data_q   <= 8'd0;
            m_valid_q  <= 1'b0;
            m_sop_q    <= 1'b0;
            m_eop_q    <= 1'b0;
            crc_done_q <= 1'b0;
            crc_ok_q   <= 1'b0;
            ferr_q     <= 1'b0;
            idx_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            crc_out_q  <= crc_out_d;
            in_frame_q <= in_frame_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_sop_q    <= m_sop_d;
            m_eop_q    <= m_eop_d;
            crc_done_q <= crc_done_d;
            crc_ok_q   <= crc_ok_d;
            ferr_q     <= ferr_d;
            idx_q      <= idx_d;
        end
    end

    assign s_ready_o   = s_ready;
    assign m_data_o    = m_data_q;
    assign m_valid_o   = m_valid_q;
    assign m_sop_o     = m_sop_q;
    assign m_eop_o     = m_eop_q;
    assign crc_out_o   = crc_out_q;
    assign crc_done_o  = crc_done_q;
    assign crc_ok_o    = crc_ok_q;
    assign frame_err_o = ferr_q;
endmodule

// File: tb/tb_crc_stream_gen.sv
// Bench for crc_stream_gen: four parameter sets share one input stream; a
// negedge monitor logs M-side beats, CRC_DONE and FRAME_ERR pulses per instance.
module tb_crc_stream_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, init, s_valid, s_sop, s_eop, m_ready;
    logic [7:0] s_data;
    logic       s_ready [4], m_valid [4], m_sop [4], m_eop [4];
    logic       crc_done [4], crc_ok [4], frame_err [4];
    logic [7:0] m_data [4];
    logic [31:0] crc_out [4];
    logic [31:0] crc_app, crc_chk, crc_ref;
    logic [7:0]  crc_c8;

    assign crc_out[0] = crc_app;
    assign crc_out[1] = crc_chk;
    assign crc_out[2] = {24'd0, crc_c8};
    assign crc_out[3] = crc_ref;

    crc_stream_gen u_app (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready[0]), .s_sop_i(s_sop), .s_eop_i(s_eop), .m_data_o(m_data[0]),
        .m_valid_o(m_valid[0]), .m_ready_i(m_ready), .m_sop_o(m_sop[0]), .m_eop_o(m_eop[0]),
        .crc_out_o(crc_app), .crc_done_o(crc_done[0]), .crc_ok_o(crc_ok[0]), .frame_err_o(frame_err[0]));

    crc_stream_gen #(.APPEND(1'b0)) u_chk (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready[1]), .s_sop_i(s_sop), .s_eop_i(s_eop), .m_data_o(m_data[1]),
        .m_valid_o(m_valid[1]), .m_ready_i(m_ready), .m_sop_o(m_sop[1]), .m_eop_o(m_eop[1]),
        .crc_out_o(crc_chk), .crc_done_o(crc_done[1]), .crc_ok_o(crc_ok[1]), .frame_err_o(frame_err[1]));

    crc_stream_gen #(.CRC_W(8), .POLY(32'h07), .INIT(32'h0)) u_c8 (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready[2]), .s_sop_i(s_sop), .s_eop_i(s_eop), .m_data_o(m_data[2]),
        .m_valid_o(m_valid[2]), .m_ready_i(m_ready), .m_sop_o(m_sop[2]), .m_eop_o(m_eop[2]),
        .crc_out_o(crc_c8), .crc_done_o(crc_done[2]), .crc_ok_o(crc_ok[2]), .frame_err_o(frame_err[2]));

    crc_stream_gen #(.REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .XOR_OUT(32'hFFFFFFFF)) u_ref (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .s_data_i(s_data), .s_valid_i(s_valid),
        .s_ready_o(s_ready[3]), .s_sop_i(s_sop), .s_eop_i(s_eop), .m_data_o(m_data[3]),
        .m_valid_o(m_valid[3]), .m_ready_i(m_ready), .m_sop_o(m_sop[3]), .m_eop_o(m_eop[3]),
        .crc_out_o(crc_ref), .crc_done_o(crc_done[3]), .crc_ok_o(crc_ok[3]), .frame_err_o(frame_err[3]));

    // Beat log entry is {sop, eop, data}.
    logic [9:0] beats [4][32];
    int nbeats [4];
    int ndone [4];
    int nferr [4];
    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (m_valid[d] && m_ready && nbeats[d] < 32) begin
                beats[d][nbeats[d]] = {m_sop[d], m_eop[d], m_data[d]};
                nbeats[d]++;
            end
            if (crc_done[d]) ndone[d]++;
            if (frame_err[d]) nferr[d]++;
        end
    end

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    typedef struct {
        string       name;
        int          dut;
        int          nb;
        logic [31:0] crc;
        logic [31:0] tail;
        int          tail_n;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        for (int d = 0; d < 4; d++) begin
            nbeats[d] = 0;
            ndone[d]  = 0;
            nferr[d]  = 0;
        end
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        clear_log();
    endtask

    // Present one byte and hold it until the default-parameter instance accepts it.
    task automatic send(input logic [7:0] d, input logic sop, input logic eop);
        logic acc;
        int   n;
        s_data = d; s_valid = 1'b1; s_sop = sop; s_eop = eop;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_ready[0];
            tick();
            n++;
        end
        check("send_accept", {31'd0, acc}, 32'd1);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < 9; i++) send(msg[i], i == 0, i == 8);
    endtask

    task automatic wait_byte76();
        int n;
        n = 0;
        while (!(m_valid[0] && m_data[0] == 8'h76) && n < 10) begin
            tick();
            n++;
        end
        check("wait_76", {31'd0, m_valid[0] && m_data[0] == 8'h76}, 32'd1);
    endtask

    initial begin
        int bad;
        int eop_bad;
        rst_n = 1'b0; init = 1'b0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        s_data = 8'd0; m_ready = 1'b1;
        clear_log();

        tbl[0] = '{"mpeg2",      0, 13, 32'h0376E6E7, 32'h0376E6E7, 4};
        tbl[1] = '{"check_pass", 1,  9, 32'h0376E6E7, 32'h00000000, 0};
        tbl[2] = '{"crc8",       2, 10, 32'h000000F4, 32'h000000F4, 1};
        tbl[3] = '{"crc32_refl", 3, 13, 32'hCBF43926, 32'h2639F4CB, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid[0]}, 32'd0);
        check("rst_m_data", {24'd0, m_data[0]}, 32'd0);
        check("rst_crc_out", crc_out[0], 32'd0);
        check("rst_done_ok_ferr", {29'd0, crc_done[0], crc_ok[0], frame_err[0]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready[0]}, 32'd1);
        tick();

        // One "123456789" packet drives all four parameter sets
        do_init();
        send_pkt();
        repeat (12) tick();
        for (int v = 0; v < 4; v++) begin
            int d;
            d = tbl[v].dut;
            check({tbl[v].name, "_crc"}, crc_out[d], tbl[v].crc);
            check({tbl[v].name, "_beats"}, nbeats[d], tbl[v].nb);
            check({tbl[v].name, "_done"}, ndone[d], 1);
            check({tbl[v].name, "_ok"}, {31'd0, crc_ok[d]}, 32'd0);
            bad = 0;
            eop_bad = 0;
            for (int i = 0; i < 9; i++)
                if (beats[d][i][7:0] !== msg[i] || beats[d][i][9] !== (i == 0)) bad++;
            for (int i = 0; i < tbl[v].nb && i < 32; i++)
                if (beats[d][i][8] !== (i == tbl[v].nb - 1)) eop_bad++;
            check({tbl[v].name, "_payload"}, bad, 0);
            check({tbl[v].name, "_eop_pos"}, eop_bad, 0);
            for (int k = 0; k < tbl[v].tail_n; k++) begin
                logic [31:0] t;
                t = tbl[v].tail >> (8 * (tbl[v].tail_n - 1 - k));
                check({tbl[v].name, "_tail"}, {24'd0, beats[d][9 + k][7:0]}, {24'd0, t[7:0]});
            end
            $display("vector %s: crc=%h beats=%0d", tbl[v].name, crc_out[d], nbeats[d]);
        end

        // Check mode: packet carrying its own CRC, then a corrupted copy
        do_init();
        send_pkt();
        do_init();
        for (int i = 0; i < 9; i++) send(msg[i], i == 0, 1'b0);
        send(8'h03, 0, 0); send(8'h76, 0, 0); send(8'hE6, 0, 0); send(8'hE7, 0, 1);
        repeat (2) tick();
        check("chk_ok_good", {31'd0, crc_ok[1]}, 32'd1);
        check("chk_done_good", ndone[1], 1);
        check("chk_eop_fwd", {22'd0, beats[1][12]}, {22'd0, 2'b01, 8'hE7});
        $display("check-mode good packet: crc_ok=%0d", crc_ok[1]);
        repeat (8) tick();
        do_init();
        for (int i = 0; i < 9; i++) send(msg[i], i == 0, 1'b0);
        send(8'h03, 0, 0); send(8'h76, 0, 0); send(8'hE6, 0, 0); send(8'hE6, 0, 1);
        repeat (2) tick();
        check("chk_ok_bad", {31'd0, crc_ok[1]}, 32'd0);
        $display("check-mode bad packet: crc_ok=%0d", crc_ok[1]);
        repeat (8) tick();

        // Backpressure during the second appended byte, with a new SOP waiting
        do_init();
        send_pkt();
        wait_byte76();
        m_ready = 1'b0;
        s_data = 8'hAA; s_valid = 1'b1; s_sop = 1'b1; s_eop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_data", {24'd0, m_data[0]}, 32'h76);
            check("bp_hold_valid", {31'd0, m_valid[0]}, 32'd1);
            check("bp_s_ready", {31'd0, s_ready[0]}, 32'd0);
            tick();
        end
        m_ready = 1'b1;
        send(8'hAA, 1, 1);
        repeat (12) tick();
        check("bp_beat_76", {22'd0, beats[0][10]}, {22'd0, 2'b00, 8'h76});
        check("bp_beat_E7", {22'd0, beats[0][12]}, {22'd0, 2'b01, 8'hE7});
        check("bp_beat_AA", {22'd0, beats[0][13]}, {22'd0, 2'b10, 8'hAA});
        check("bp_done", ndone[0], 2);
        $display("backpressure: beats=%0d", nbeats[0]);

        // SOP mid-packet restarts the CRC
        do_init();
        send(8'h31, 1, 0); send(8'h32, 0, 0);
        send_pkt();
        repeat (12) tick();
        check("sop_mid_ferr", nferr[0], 1);
        check("sop_mid_crc", crc_out[0], 32'h0376E6E7);
        $display("restart: ferr=%0d crc=%h", nferr[0], crc_out[0]);

        // Unframed byte is forwarded but not folded
        do_init();
        send(8'h55, 0, 0);
        send_pkt();
        repeat (12) tick();
        check("unframed_ferr", nferr[0], 1);
        check("unframed_crc", crc_out[0], 32'h0376E6E7);
        check("unframed_fwd", {22'd0, beats[0][0]}, {22'd0, 2'b00, 8'h55});
        $display("unframed: ferr=%0d crc=%h", nferr[0], crc_out[0]);

        // INIT aborts APPEND
        do_init();
        send_pkt();
        wait_byte76();
        init = 1'b1;
        tick();
        init = 1'b0;
        check("init_m_valid", {31'd0, m_valid[0]}, 32'd0);
        bad = nbeats[0];
        repeat (8) tick();
        check("init_no_more", nbeats[0], bad);
        $display("init abort: beats=%0d", nbeats[0]);

        // Reset mid-APPEND, then a clean packet
        do_init();
        send_pkt();
        wait_byte76();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_m_valid", {31'd0, m_valid[0]}, 32'd0);
        check("rstmid_crc_out", crc_out[0], 32'd0);
        check("rstmid_m_data", {24'd0, m_data[0]}, 32'd0);
        clear_log();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("rstmid_no_beats", nbeats[0], 0);
        send_pkt();
        repeat (12) tick();
        check("after_rst_crc", crc_out[0], 32'h0376E6E7);
        check("after_rst_beats", nbeats[0], 13);
        check("after_rst_done", ndone[0], 1);
        $display("after reset: crc=%h beats=%0d", crc_out[0], nbeats[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/crc_stream_gen.md
Name: crc_stream_gen

Overview:
- Parametrised byte-stream CRC engine for the T2-MI packer path.
- Generalises the fixed CRC-32/MPEG-2 byte calculator: CRC width, polynomial, seed, reflection and final XOR are all configurable.
- Adds packet framing with valid/ready handshakes. Two modes: append mode inserts the CRC bytes after each packet; check mode verifies a packet that already carries its CRC.

Parameters:
CRC_W, 32, CRC width in bits; must be a multiple of 8, range 8..32
POLY, 32'h04C11DB7, generator polynomial, implicit top bit omitted; low CRC_W bits used
INIT, 32'hFFFFFFFF, seed loaded on the start-of-packet byte; low CRC_W bits used
XOR_OUT, 32'h00000000, final XOR applied to the result
REFLECT_IN, 0, 1 = process each input byte LSB-first
REFLECT_OUT, 0, 1 = bit-reverse the register before XOR_OUT
APPEND, 1, 1 = append CRC to each packet; 0 = check-only mode
RESIDUE, 32'h00000000, expected raw register value after data plus CRC (check mode)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
INIT  in  1  synchronous clear: register to INIT, state to PASS, in_frame cleared
S_DATA  in  8  input byte
S_VALID  in  1  input byte valid
S_READY  out  1  engine accepts a byte
S_SOP  in  1  first byte of packet
S_EOP  in  1  last byte of packet
M_DATA  out  8  output byte
M_VALID  out  1  output byte valid
M_READY  in  1  downstream accepts
M_SOP  out  1  first output byte of packet
M_EOP  out  1  last output byte of packet (last CRC byte in append mode)
CRC_OUT  out  CRC_W  final CRC of the last completed packet
CRC_DONE  out  1  one-cycle pulse when CRC_OUT is updated
CRC_OK  out  1  check mode: residue matched on the last packet (held)
FRAME_ERR  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset: the CRC register is loaded with INIT.
  - All outputs are 0: M_*, CRC_OUT, CRC_DONE, CRC_OK, FRAME_ERR.
  - State is PASS and in_frame = 0.
  - S_READY may assert from the first clock after reset release.
- Handshakes:
  - Accept on S_VALID & S_READY.
  - S_READY = (state == PASS) & (!M_VALID | M_READY).
  - M side is one output register: an accepted byte appears on M_DATA the next cycle (latency 1).
  - M_DATA, M_SOP and M_EOP stay stable while M_VALID & !M_READY.
- CRC update: bitwise LFSR unrolled 8 times per accepted byte, MSB-first unless REFLECT_IN.
  - Seed is INIT when S_SOP = 1, otherwise the current register.
  - Bytes accepted with in_frame = 0 and S_SOP = 0 are forwarded but not folded into the CRC, and FRAME_ERR pulses.
  - S_SOP while in_frame = 1 restarts the CRC with INIT and FRAME_ERR pulses.
- EOP byte accepted (SOP+EOP on the same byte is a valid 1-byte packet):
  - Next cycle: CRC_OUT = (REFLECT_OUT ? reverse(reg) : reg) ^ XOR_OUT, CRC_DONE = 1 for one cycle, in_frame = 0.
  - Append mode: the EOP byte is forwarded with M_EOP = 0. State goes to APPEND, which emits CRC_W/8 bytes of CRC_OUT, MSB byte first if REFLECT_OUT = 0, LSB byte first if 1.
  - In APPEND, each emitted byte advances on M handshake; the last byte carries M_EOP = 1, then state returns to PASS.
  - Check mode: bytes pass unchanged, M_EOP follows S_EOP, and CRC_OK = (raw reg == RESIDUE), updated alongside CRC_DONE.
- INIT input overrides everything except reset.
  - It aborts APPEND and drops any pending M byte (M_VALID = 0).
  - If INIT and an accepted byte coincide, INIT wins and the byte is discarded.
- Reset mid-APPEND: reset values apply immediately and no stale CRC bytes are emitted afterwards.
- M_SOP mirrors S_SOP of the forwarded byte; CRC bytes carry M_SOP = 0.

Test Plan:
- Default params, APPEND = 1, bytes "123456789" (0x31..0x39), SOP on 0x31, EOP on 0x39, M_READY = 1 -> M stream is 9 bytes then 03 76 E6 E7, M_EOP only on E7; CRC_OUT = 0x0376E6E7; CRC_DONE pulses once.
- APPEND = 0, stream "123456789" followed by 03 76 E6 E7, EOP on E7 -> CRC_OK = 1. Repeat with the last byte E6 -> CRC_OK = 0.
- CRC_W = 8, POLY = 0x07, INIT = 0, APPEND = 1, "123456789" -> appended byte F4; CRC_OUT = 0xF4.
- REFLECT_IN = REFLECT_OUT = 1, XOR_OUT = 0xFFFFFFFF, "123456789" -> CRC_OUT = 0xCBF43926; appended bytes 26 39 F4 CB.
- Default params: M_READY low for 3 cycles during the second appended byte -> M_DATA = 0x76 is held stable, S_READY = 0 throughout. A new SOP issued during APPEND is not accepted until after E7.
- Framing and reset:
  - S_SOP mid-packet -> FRAME_ERR pulses 1 cycle and the CRC restarts.
  - RST asserted mid-APPEND -> all outputs 0, no further CRC bytes.
  - A following "123456789" packet -> 0x0376E6E7 again.
